// File: rtl/amci_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : amci_pkg
//  Description : Shared constants, FSM state encodings and command/response
//                field-offset helpers for the AMCI command executor.
//  Revision    : 1.0 - initial release
// ============================================================================
package amci_pkg;

    localparam int AXI_SIZE_WIDTH = 3;
    localparam int AXI_RESP_WIDTH = 2;

    localparam logic [AXI_RESP_WIDTH-1:0] RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_WIDTH-1:0] RESP_SLVERR = 2'b10;

    // Executor FSM state encodings
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_GUARD = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

    // Command word layout: {tag[7:0], op, size[2:0], addr, wdata}
    function automatic int cmd_width(input int data_w, input int addr_w);
        return data_w + addr_w + 12;
    endfunction

    function automatic int cmd_addr_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int cmd_size_lsb(input int data_w, input int addr_w);
        return data_w + addr_w;
    endfunction

    function automatic int cmd_op_bit(input int data_w, input int addr_w);
        return data_w + addr_w + 3;
    endfunction

    function automatic int cmd_tag_lsb(input int data_w, input int addr_w);
        return data_w + addr_w + 4;
    endfunction

    // Response word layout: {tag[7:0], op, resp[1:0], rdata}
    function automatic int rsp_width(input int data_w);
        return data_w + 11;
    endfunction

    function automatic int rsp_resp_lsb(input int data_w);
        return data_w;
    endfunction

endpackage : amci_pkg
`default_nettype wire

// File: rtl/amci_cmd_executor.sv
`default_nettype none
// ============================================================================
//  Module      : amci_cmd_executor
//  Description : Turns single-beat AXI-Stream command words into one AMCI
//                read or write each, waits for completion and returns one
//                AXI-Stream response word. One command in flight at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module amci_cmd_executor
    import amci_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W+ADDR_W+12-1:0]   CMD_TDATA,
    input  logic                          CMD_TVALID,
    output logic                          CMD_TREADY,
    output logic [DATA_W+11-1:0]          RSP_TDATA,
    output logic                          RSP_TVALID,
    input  logic                          RSP_TREADY,
    output logic [ADDR_W-1:0]             AMCI_WADDR,
    output logic [DATA_W-1:0]             AMCI_WDATA,
    output logic [2:0]                    AMCI_WSIZE,
    output logic                          AMCI_WRITE,
    input  logic [1:0]                    AMCI_WRESP,
    input  logic                          AMCI_WIDLE,
    output logic [ADDR_W-1:0]             AMCI_RADDR,
    output logic [2:0]                    AMCI_RSIZE,
    output logic                          AMCI_READ,
    input  logic [DATA_W-1:0]             AMCI_RDATA,
    input  logic [1:0]                    AMCI_RRESP,
    input  logic                          AMCI_RIDLE,
    output logic [31:0]                   CMD_COUNT,
    output logic [31:0]                   ERR_COUNT
);

    localparam int c_cmd_w    = cmd_width(DATA_W, ADDR_W);
    localparam int c_rsp_w    = rsp_width(DATA_W);
    localparam int c_addr_lsb = cmd_addr_lsb(DATA_W);
    localparam int c_size_lsb = cmd_size_lsb(DATA_W, ADDR_W);
    localparam int c_op_bit   = cmd_op_bit(DATA_W, ADDR_W);
    localparam int c_tag_lsb  = cmd_tag_lsb(DATA_W, ADDR_W);
    localparam int c_resp_lsb = rsp_resp_lsb(DATA_W);

    // Largest legal size code: one full data-bus beat
    localparam logic [2:0] c_max_size = 3'($clog2(DATA_W / 8));

    logic [2:0]          r_state;
    logic [c_cmd_w-1:0]  r_cmd;
    logic [c_rsp_w-1:0]  r_rsp;
    logic [ADDR_W-1:0]   r_waddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [2:0]          r_wsize;
    logic [ADDR_W-1:0]   r_raddr;
    logic [2:0]          r_rsize;
    logic [31:0]         r_cmd_count;
    logic [31:0]         r_err_count;

    logic [DATA_W-1:0]   w_wdata;
    logic [ADDR_W-1:0]   w_addr;
    logic [2:0]          w_size;
    logic                w_op;
    logic [7:0]          w_tag;
    logic [ADDR_W-1:0]   w_align_mask;
    logic                w_reject;
    logic                w_cmd_hs;
    logic                w_rsp_hs;
    logic                w_done;

    // Latched command fields
    assign w_wdata = r_cmd[DATA_W-1:0];
    assign w_addr  = r_cmd[c_addr_lsb +: ADDR_W];
    assign w_size  = r_cmd[c_size_lsb +: AXI_SIZE_WIDTH];
    assign w_op    = r_cmd[c_op_bit];
    assign w_tag   = r_cmd[c_tag_lsb +: 8];

    // Oversize or misaligned commands are answered with SLVERR and never issued
    assign w_align_mask = (ADDR_W'(1) << w_size) - ADDR_W'(1);
    assign w_reject     = (w_size > c_max_size) || ((w_addr & w_align_mask) != '0);

    // Completion of the issued transaction is signalled by the matching engine going idle
    assign w_done   = w_op ? AMCI_WIDLE : AMCI_RIDLE;

    assign CMD_TREADY = (r_state == ST_IDLE) && AMCI_WIDLE && AMCI_RIDLE && !reset;
    assign w_cmd_hs   = CMD_TVALID && CMD_TREADY;
    assign RSP_TVALID = (r_state == ST_RESP);
    assign w_rsp_hs   = RSP_TVALID && RSP_TREADY;

    assign RSP_TDATA  = r_rsp;
    assign AMCI_WRITE = (r_state == ST_ISSUE) && w_op;
    assign AMCI_READ  = (r_state == ST_ISSUE) && !w_op;
    assign AMCI_WADDR = r_waddr;
    assign AMCI_WDATA = r_wdata;
    assign AMCI_WSIZE = r_wsize;
    assign AMCI_RADDR = r_raddr;
    assign AMCI_RSIZE = r_rsize;
    assign CMD_COUNT  = r_cmd_count;
    assign ERR_COUNT  = r_err_count;

    // Command sequencing FSM with command/response capture and AMCI operand registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cmd   <= '0;
            r_rsp   <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_wsize <= '0;
            r_raddr <= '0;
            r_rsize <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_hs) begin
                        r_cmd   <= CMD_TDATA;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_reject) begin
                        r_rsp   <= {w_tag, w_op, RESP_SLVERR, {DATA_W{1'b0}}};
                        r_state <= ST_RESP;
                    end else begin
                        if (w_op) begin
                            r_waddr <= w_addr;
                            r_wdata <= w_wdata;
                            r_wsize <= w_size;
                        end else begin
                            r_raddr <= w_addr;
                            r_rsize <= w_size;
                        end
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: r_state <= ST_GUARD;
                ST_GUARD: r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (w_done) begin
                        if (w_op)
                            r_rsp <= {w_tag, w_op, AMCI_WRESP, {DATA_W{1'b0}}};
                        else
                            r_rsp <= {w_tag, w_op, AMCI_RRESP, AMCI_RDATA};
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_rsp_hs)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Completion and error counters advance on the response handshake and wrap freely
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd_count <= '0;
            r_err_count <= '0;
        end else if (w_rsp_hs) begin
            r_cmd_count <= r_cmd_count + 32'd1;
            if (r_rsp[c_resp_lsb +: AXI_RESP_WIDTH] != RESP_OKAY)
                r_err_count <= r_err_count + 32'd1;
        end
    end

endmodule : amci_cmd_executor
`default_nettype wire

// File: tb/tb_amci_cmd_executor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_amci_cmd_executor
//  Description : Directed self-checking bench for amci_cmd_executor with a
//                simple behavioural AMCI master model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_amci_cmd_executor;

    localparam int DW = 32;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [AW+DW+11:0] CMD_TDATA = '0;
    logic            CMD_TVALID = 1'b0;
    logic            CMD_TREADY;
    logic [DW+10:0]  RSP_TDATA;
    logic            RSP_TVALID;
    logic            RSP_TREADY = 1'b0;
    logic [AW-1:0]   AMCI_WADDR, AMCI_RADDR;
    logic [DW-1:0]   AMCI_WDATA;
    logic [2:0]      AMCI_WSIZE, AMCI_RSIZE;
    logic            AMCI_WRITE, AMCI_READ;
    logic [1:0]      AMCI_WRESP = 2'b00;
    logic [1:0]      AMCI_RRESP = 2'b00;
    logic [DW-1:0]   AMCI_RDATA = '0;
    logic            AMCI_WIDLE, AMCI_RIDLE;
    logic [31:0]     CMD_COUNT, ERR_COUNT;

    int n_checks = 0;
    int n_fail   = 0;

    // Master model state
    int         slave_lat = 1;
    logic       hold_busy = 1'b0;
    int         wcnt = 0;
    int         rcnt = 0;
    int         n_wr = 0;
    int         n_rd = 0;
    logic       both_high = 1'b0;
    logic [AW-1:0] cap_waddr = '0, cap_raddr = '0;
    logic [DW-1:0] cap_wdata = '0;
    logic [2:0]    cap_wsize = '0, cap_rsize = '0;

    always #5 clk = ~clk;

    amci_cmd_executor #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .CMD_TDATA(CMD_TDATA), .CMD_TVALID(CMD_TVALID), .CMD_TREADY(CMD_TREADY),
        .RSP_TDATA(RSP_TDATA), .RSP_TVALID(RSP_TVALID), .RSP_TREADY(RSP_TREADY),
        .AMCI_WADDR(AMCI_WADDR), .AMCI_WDATA(AMCI_WDATA), .AMCI_WSIZE(AMCI_WSIZE),
        .AMCI_WRITE(AMCI_WRITE), .AMCI_WRESP(AMCI_WRESP), .AMCI_WIDLE(AMCI_WIDLE),
        .AMCI_RADDR(AMCI_RADDR), .AMCI_RSIZE(AMCI_RSIZE), .AMCI_READ(AMCI_READ),
        .AMCI_RDATA(AMCI_RDATA), .AMCI_RRESP(AMCI_RRESP), .AMCI_RIDLE(AMCI_RIDLE),
        .CMD_COUNT(CMD_COUNT), .ERR_COUNT(ERR_COUNT)
    );

    // Behavioural AMCI master: busy for slave_lat cycles after each strobe
    assign AMCI_WIDLE = (wcnt == 0) && !hold_busy;
    assign AMCI_RIDLE = (rcnt == 0) && !hold_busy;

    always @(posedge clk) begin
        if (AMCI_WRITE && AMCI_READ) both_high <= 1'b1;
        if (AMCI_WRITE) begin
            wcnt <= slave_lat; n_wr <= n_wr + 1;
            cap_waddr <= AMCI_WADDR; cap_wdata <= AMCI_WDATA; cap_wsize <= AMCI_WSIZE;
        end else if (wcnt != 0) wcnt <= wcnt - 1;
        if (AMCI_READ) begin
            rcnt <= slave_lat; n_rd <= n_rd + 1;
            cap_raddr <= AMCI_RADDR; cap_rsize <= AMCI_RSIZE;
        end else if (rcnt != 0) rcnt <= rcnt - 1;
    end

    function automatic logic [AW+DW+11:0] mk_cmd(input logic [7:0] tag, input logic op,
                                                 input logic [2:0] size, input logic [AW-1:0] addr,
                                                 input logic [DW-1:0] wdata);
        return {tag, op, size, addr, wdata};
    endfunction

    // Present one command and complete its handshake (bounded)
    task automatic send_cmd(input logic [AW+DW+11:0] cmd);
        int cyc;
        @(negedge clk);
        CMD_TDATA = cmd; CMD_TVALID = 1'b1; cyc = 0;
        while (!CMD_TREADY && cyc < 200) begin @(negedge clk); cyc++; end
        if (!CMD_TREADY) begin
            n_checks++; n_fail++;
            $display("FAIL cmd_handshake_timeout: CMD_TREADY=%b required 1", CMD_TREADY);
        end
        @(posedge clk); #1 CMD_TVALID = 1'b0;
    endtask

    // Wait for a response (bounded), capture it and consume it
    task automatic wait_rsp(output int cyc, output logic [DW+10:0] data);
        cyc = 0;
        while (!RSP_TVALID && cyc < 200) begin @(negedge clk); cyc++; end
        n_checks++;
        if (RSP_TVALID !== 1'b1) begin
            n_fail++; $display("FAIL rsp_timeout: RSP_TVALID=%b required 1", RSP_TVALID);
        end
        data = RSP_TDATA;
        RSP_TREADY = 1'b1;
        @(posedge clk); #1 RSP_TREADY = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (CMD_TREADY !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b required 0", CMD_TREADY); end
        n_checks++;
        if ({RSP_TVALID, AMCI_WRITE, AMCI_READ} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes: got %b required 000", {RSP_TVALID, AMCI_WRITE, AMCI_READ});
        end
        n_checks++;
        if ({AMCI_WADDR, AMCI_WDATA, AMCI_WSIZE, AMCI_RADDR, AMCI_RSIZE, CMD_COUNT, ERR_COUNT} !== '0) begin
            n_fail++; $display("FAIL reset_regs: waddr=%h wdata=%h raddr=%h cnt=%0d err=%0d required 0",
                               AMCI_WADDR, AMCI_WDATA, AMCI_RADDR, CMD_COUNT, ERR_COUNT);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (CMD_TREADY !== 1'b1) begin n_fail++; $display("FAIL idle_tready: got %b required 1", CMD_TREADY); end
    endtask

    task automatic test_write();
        int cyc; logic [DW+10:0] r;
        slave_lat = 1; AMCI_WRESP = 2'b00;
        send_cmd(mk_cmd(8'h11, 1'b1, 3'd2, 32'hC000_0004, 32'hA1B1C1D1));
        wait_rsp(cyc, r);
        n_checks++;
        if (n_wr !== 1 || n_rd !== 0) begin n_fail++; $display("FAIL wr_strobes: wr=%0d rd=%0d required 1 0", n_wr, n_rd); end
        n_checks++;
        if ({cap_waddr, cap_wdata, cap_wsize} !== {32'hC000_0004, 32'hA1B1C1D1, 3'd2}) begin
            n_fail++; $display("FAIL wr_operands: addr=%h data=%h size=%0d required C0000004 A1B1C1D1 2",
                               cap_waddr, cap_wdata, cap_wsize);
        end
        n_checks++;
        if (r !== {8'h11, 1'b1, 2'b00, 32'h0}) begin n_fail++; $display("FAIL wr_rsp: got %h required %h", r, {8'h11, 1'b1, 2'b00, 32'h0}); end
        n_checks++;
        if (cyc > 5) begin n_fail++; $display("FAIL wr_latency: got %0d required <=5", cyc); end
        n_checks++;
        if (CMD_COUNT !== 32'd1 || ERR_COUNT !== 32'd0) begin n_fail++; $display("FAIL wr_counts: cmd=%0d err=%0d required 1 0", CMD_COUNT, ERR_COUNT); end
    endtask

    task automatic test_read();
        int cyc; logic [DW+10:0] r;
        slave_lat = 3; AMCI_RRESP = 2'b00; AMCI_RDATA = 32'hA2B2C2D2;
        send_cmd(mk_cmd(8'h22, 1'b0, 3'd2, 32'hC000_0008, 32'hDEAD_BEEF));
        wait_rsp(cyc, r);
        n_checks++;
        if (n_rd !== 1 || n_wr !== 1) begin n_fail++; $display("FAIL rd_strobes: rd=%0d wr=%0d required 1 1", n_rd, n_wr); end
        n_checks++;
        if ({cap_raddr, cap_rsize} !== {32'hC000_0008, 3'd2}) begin
            n_fail++; $display("FAIL rd_operands: addr=%h size=%0d required C0000008 2", cap_raddr, cap_rsize);
        end
        n_checks++;
        if (r !== {8'h22, 1'b0, 2'b00, 32'hA2B2C2D2}) begin n_fail++; $display("FAIL rd_rsp: got %h required %h", r, {8'h22, 1'b0, 2'b00, 32'hA2B2C2D2}); end
        n_checks++;
        if (CMD_COUNT !== 32'd2) begin n_fail++; $display("FAIL rd_count: got %0d required 2", CMD_COUNT); end
    endtask

    task automatic test_reject();
        int cyc; logic [DW+10:0] r;
        // Misaligned word access
        send_cmd(mk_cmd(8'h33, 1'b1, 3'd2, 32'hC000_0002, 32'h1234_5678));
        wait_rsp(cyc, r);
        n_checks++;
        if (r !== {8'h33, 1'b1, 2'b10, 32'h0}) begin n_fail++; $display("FAIL misalign_rsp: got %h required %h", r, {8'h33, 1'b1, 2'b10, 32'h0}); end
        n_checks++;
        if (cyc > 2) begin n_fail++; $display("FAIL misalign_latency: got %0d required <=2", cyc); end
        n_checks++;
        if (ERR_COUNT !== 32'd1 || CMD_COUNT !== 32'd3) begin n_fail++; $display("FAIL misalign_counts: cmd=%0d err=%0d required 3 1", CMD_COUNT, ERR_COUNT); end
        // Oversize access on a 32-bit bus
        send_cmd(mk_cmd(8'h44, 1'b0, 3'd3, 32'hC000_0000, 32'h0));
        wait_rsp(cyc, r);
        n_checks++;
        if (r !== {8'h44, 1'b0, 2'b10, 32'h0}) begin n_fail++; $display("FAIL oversize_rsp: got %h required %h", r, {8'h44, 1'b0, 2'b10, 32'h0}); end
        n_checks++;
        if (n_wr !== 1 || n_rd !== 1) begin n_fail++; $display("FAIL reject_no_strobe: wr=%0d rd=%0d required 1 1", n_wr, n_rd); end
        n_checks++;
        if (ERR_COUNT !== 32'd2) begin n_fail++; $display("FAIL oversize_err: got %0d required 2", ERR_COUNT); end
        // Legal byte read that the slave errors
        slave_lat = 2; AMCI_RRESP = 2'b10; AMCI_RDATA = 32'h0000_00EE;
        send_cmd(mk_cmd(8'h55, 1'b0, 3'd0, 32'hC000_0003, 32'h0));
        wait_rsp(cyc, r);
        AMCI_RRESP = 2'b00;
        n_checks++;
        if (r !== {8'h55, 1'b0, 2'b10, 32'h0000_00EE}) begin n_fail++; $display("FAIL slverr_rsp: got %h required %h", r, {8'h55, 1'b0, 2'b10, 32'h0000_00EE}); end
        n_checks++;
        if (ERR_COUNT !== 32'd3 || CMD_COUNT !== 32'd5) begin n_fail++; $display("FAIL slverr_counts: cmd=%0d err=%0d required 5 3", CMD_COUNT, ERR_COUNT); end
    endtask

    task automatic test_back_to_back();
        int cyc; logic [DW+10:0] r, snap; logic bad;
        slave_lat = 1; AMCI_WRESP = 2'b00;
        send_cmd(mk_cmd(8'h66, 1'b1, 3'd1, 32'h0000_0010, 32'h0000_BEEF));
        cyc = 0;
        while (!RSP_TVALID && cyc < 200) begin @(negedge clk); cyc++; end
        snap = RSP_TDATA; bad = 1'b0;
        CMD_TDATA = mk_cmd(8'h77, 1'b0, 3'd2, 32'h0000_0020, 32'h0);
        CMD_TVALID = 1'b1;
        AMCI_RDATA = 32'h7777_0000;
        repeat (20) begin
            @(negedge clk);
            if (RSP_TVALID !== 1'b1 || RSP_TDATA !== snap || CMD_TREADY !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad || snap !== {8'h66, 1'b1, 2'b00, 32'h0}) begin
            n_fail++; $display("FAIL backpressure_hold: rsp=%h required %h stable, cmd_tready held 0 (violation=%b)",
                               snap, {8'h66, 1'b1, 2'b00, 32'h0}, bad);
        end
        n_checks++;
        if (CMD_COUNT !== 32'd5) begin n_fail++; $display("FAIL backpressure_count: got %0d required 5", CMD_COUNT); end
        RSP_TREADY = 1'b1;
        @(posedge clk); #1 RSP_TREADY = 1'b0;
        cyc = 0;
        while (!CMD_TREADY && cyc < 200) begin @(negedge clk); cyc++; end
        @(posedge clk); #1 CMD_TVALID = 1'b0;
        wait_rsp(cyc, r);
        n_checks++;
        if (r !== {8'h77, 1'b0, 2'b00, 32'h7777_0000}) begin n_fail++; $display("FAIL second_cmd_rsp: got %h required %h", r, {8'h77, 1'b0, 2'b00, 32'h7777_0000}); end
        n_checks++;
        if (CMD_COUNT !== 32'd7 || n_rd !== 3 || n_wr !== 2) begin
            n_fail++; $display("FAIL second_cmd_counts: cmd=%0d rd=%0d wr=%0d required 7 3 2", CMD_COUNT, n_rd, n_wr);
        end
    endtask

    task automatic test_reset_in_wait();
        int cyc, rd_before; logic bad;
        slave_lat = 10;
        send_cmd(mk_cmd(8'h88, 1'b0, 3'd2, 32'h0000_0040, 32'h0));
        repeat (4) @(negedge clk);
        hold_busy = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({RSP_TVALID, AMCI_WRITE, AMCI_READ, CMD_TREADY} !== 4'b0000 || CMD_COUNT !== 32'd0 || ERR_COUNT !== 32'd0) begin
            n_fail++; $display("FAIL midreset_state: vld/wr/rd/rdy=%b cmd=%0d err=%0d required 0000 0 0",
                               {RSP_TVALID, AMCI_WRITE, AMCI_READ, CMD_TREADY}, CMD_COUNT, ERR_COUNT);
        end
        @(negedge clk);
        reset = 1'b0;
        rd_before = n_rd; bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (CMD_TREADY !== 1'b0 || RSP_TVALID !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin n_fail++; $display("FAIL midreset_busy_gate: CMD_TREADY or RSP_TVALID rose while master busy, required 0"); end
        hold_busy = 1'b0;
        cyc = 0;
        while (!(AMCI_WIDLE && AMCI_RIDLE) && cyc < 200) begin @(negedge clk); cyc++; end
        @(negedge clk);
        n_checks++;
        if (CMD_TREADY !== 1'b1 || RSP_TVALID !== 1'b0 || n_rd !== rd_before) begin
            n_fail++; $display("FAIL midreset_recover: rdy=%b vld=%b rd=%0d required 1 0 %0d",
                               CMD_TREADY, RSP_TVALID, n_rd, rd_before);
        end
        n_checks++;
        if (both_high !== 1'b0) begin n_fail++; $display("FAIL strobe_exclusive: both_high=%b required 0", both_high); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_reject();
        test_back_to_back();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_amci_cmd_executor
`default_nettype wire
